writeback_arbiter: RTL and testbench

// - Writer side of register_file: merges ALU results and load responses into the single write port.

---
 rtl/writeback_arbiter.sv | 99 +++++++++
 tb/tb_writeback_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: merges ALU results and load responses, extends load data, tracks pending loads.
// Optional retire counter output o_retire_count when WB_RETIRE_COUNT_EN is defined.
module writeback_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
`ifdef WB_RETIRE_COUNT_EN
   , parameter int unsigned RETIRE_WIDTH = 64
`endif
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_alu_valid,
   output logic                       o_alu_ready,
   input  logic [ADDR_WIDTH-1:0]      i_alu_rd,
   input  logic [DATA_WIDTH-1:0]      i_alu_data,
   input  logic                       i_load_valid,
   output logic                       o_load_ready,
   input  logic [ADDR_WIDTH-1:0]      i_load_rd,
   input  logic [DATA_WIDTH-1:0]      i_load_data,
   input  logic [2:0]                 i_load_funct3,
   input  logic [1:0]                 i_load_byte_offset,
   input  logic                       i_issue_load_valid,
   input  logic [ADDR_WIDTH-1:0]      i_issue_load_rd,
   output logic                       o_rf_write_enable,
   output logic [ADDR_WIDTH-1:0]      o_rf_write_address,
   output logic [DATA_WIDTH-1:0]      o_rf_write_data,
   output logic [2**ADDR_WIDTH-1:0]   o_rd_busy
`ifdef WB_RETIRE_COUNT_EN
   , output logic [RETIRE_WIDTH-1:0]  o_retire_count
`endif
);

   localparam int unsigned NREGS = 2**ADDR_WIDTH;

   logic                  load_fire;
   logic                  alu_fire;
   logic                  wb_fire;
   logic [ADDR_WIDTH-1:0] wb_rd;
   logic [DATA_WIDTH-1:0] wb_data;
   logic [7:0]            load_byte;
   logic [15:0]           load_half;
   logic [DATA_WIDTH-1:0] load_ext;
   logic [NREGS-1:0]      busy_next;

   // Loads have fixed priority; the ALU only gets the port on load-free cycles.
   assign o_load_ready = !reset;
   assign o_alu_ready  = !reset && !i_load_valid;
   assign load_fire    = i_load_valid && o_load_ready;
   assign alu_fire     = i_alu_valid && o_alu_ready;
   assign wb_fire      = load_fire || alu_fire;
   assign wb_rd        = load_fire ? i_load_rd : i_alu_rd;
   assign wb_data      = load_fire ? load_ext : i_alu_data;

   // Lane extraction and sign/zero extension of the returned memory word.
   always_comb begin
      load_byte = i_load_data[{i_load_byte_offset, 3'b000} +: 8];
      load_half = i_load_data[{i_load_byte_offset[1], 4'b0000} +: 16];
      case (i_load_funct3)
         3'b000:  load_ext = {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
         3'b001:  load_ext = {{(DATA_WIDTH-16){load_half[15]}}, load_half};
         3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, load_byte};
         3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, load_half};
         default: load_ext = i_load_data;
      endcase
   end

   // Returning load clears its bit; a new issue to the same rd wins; x0 never busy.
   always_comb begin
      busy_next = o_rd_busy;
      if (load_fire) busy_next[i_load_rd] = 1'b0;
      if (i_issue_load_valid) busy_next[i_issue_load_rd] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         o_rf_write_enable  <= 1'b0;
         o_rf_write_address <= '0;
         o_rf_write_data    <= '0;
         o_rd_busy          <= '0;
      end else begin
         o_rf_write_enable <= wb_fire && (wb_rd != '0);
         // Address/data only move on a real write so they hold the last written values.
         if (wb_fire && (wb_rd != '0)) begin
            o_rf_write_address <= wb_rd;
            o_rf_write_data    <= wb_data;
         end
         o_rd_busy <= busy_next;
      end
   end

`ifdef WB_RETIRE_COUNT_EN
   always_ff @(posedge clk) begin
      if (reset) o_retire_count <= '0;
      else if (wb_fire) o_retire_count <= o_retire_count + RETIRE_WIDTH'(1);
   end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with an expected-write queue checked one cycle after each drive.
module tb_writeback_arbiter;

   typedef struct {
      logic        we;
      logic        chk_ad;
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_alu_valid;
   logic        o_alu_ready;
   logic [4:0]  i_alu_rd;
   logic [31:0] i_alu_data;
   logic        i_load_valid;
   logic        o_load_ready;
   logic [4:0]  i_load_rd;
   logic [31:0] i_load_data;
   logic [2:0]  i_load_funct3;
   logic [1:0]  i_load_byte_offset;
   logic        i_issue_load_valid;
   logic [4:0]  i_issue_load_rd;
   logic        o_rf_write_enable;
   logic [4:0]  o_rf_write_address;
   logic [31:0] o_rf_write_data;
   logic [31:0] o_rd_busy;
`ifdef WB_RETIRE_COUNT_EN
   logic [63:0] o_retire_count;
`endif

   int          total = 0;
   int          bad = 0;
   exp_t        q[$];
   logic [4:0]  last_addr;
   logic [31:0] last_data;
   logic        last_known;
   logic [31:0] m_busy;
   logic [63:0] m_count;

   writeback_arbiter dut (
      .clk(clk), .reset(reset),
      .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready),
      .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
      .i_load_valid(i_load_valid), .o_load_ready(o_load_ready),
      .i_load_rd(i_load_rd), .i_load_data(i_load_data),
      .i_load_funct3(i_load_funct3), .i_load_byte_offset(i_load_byte_offset),
      .i_issue_load_valid(i_issue_load_valid), .i_issue_load_rd(i_issue_load_rd),
      .o_rf_write_enable(o_rf_write_enable), .o_rf_write_address(o_rf_write_address),
      .o_rf_write_data(o_rf_write_data), .o_rd_busy(o_rd_busy)
`ifdef WB_RETIRE_COUNT_EN
      , .o_retire_count(o_retire_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ext_model(input logic [31:0] d, input logic [2:0] f3, input logic [1:0] off);
      logic [31:0] sh;
      sh = d >> (off * 8);
      case (f3)
         3'b000: return {{24{sh[7]}}, sh[7:0]};
         3'b100: return {24'h0, sh[7:0]};
         3'b001: begin
            sh = off[1] ? (d >> 16) : d;
            return {{16{sh[15]}}, sh[15:0]};
         end
         3'b101: begin
            sh = off[1] ? (d >> 16) : d;
            return {16'h0, sh[15:0]};
         end
         default: return d;
      endcase
   endfunction

   // One non-reset cycle: drive, check readys, predict, clock, compare against the queue head.
   task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                       input logic [2:0] f3, input logic [1:0] off,
                       input logic iv, input logic [4:0] ird);
      exp_t e;
      exp_t got;
      i_alu_valid = av; i_alu_rd = ard; i_alu_data = adata;
      i_load_valid = lv; i_load_rd = lrd; i_load_data = ldata;
      i_load_funct3 = f3; i_load_byte_offset = off;
      i_issue_load_valid = iv; i_issue_load_rd = ird;
      #1;
      chk("alu_ready", 64'(o_alu_ready), 64'(!lv));
      chk("load_ready", 64'(o_load_ready), 64'd1);
      e.we = 1'b0; e.chk_ad = last_known; e.addr = last_addr; e.data = last_data;
      if (lv || av) begin
         e.addr = lv ? lrd : ard;
         e.data = lv ? ext_model(ldata, f3, off) : adata;
         e.we = (e.addr != 5'd0);
         e.chk_ad = e.we ? 1'b1 : last_known;
         if (e.we) begin
            last_addr = e.addr; last_data = e.data; last_known = 1'b1;
         end else begin
            e.addr = last_addr; e.data = last_data;
         end
         m_count = m_count + 64'd1;
      end
      if (lv) m_busy[lrd] = 1'b0;
      if (iv) m_busy[ird] = 1'b1;
      m_busy[0] = 1'b0;
      q.push_back(e);
      @(posedge clk);
      #1;
      got = q.pop_front();
      chk("we", 64'(o_rf_write_enable), 64'(got.we));
      if (got.chk_ad) begin
         chk("addr", 64'(o_rf_write_address), 64'(got.addr));
         chk("data", 64'(o_rf_write_data), 64'(got.data));
      end
      chk("busy", 64'(o_rd_busy), 64'(m_busy));
`ifdef WB_RETIRE_COUNT_EN
      chk("retire", o_retire_count, m_count);
`endif
   endtask

   task automatic do_reset(input logic av);
      reset = 1'b1;
      i_alu_valid = av; i_alu_rd = 5'd4; i_alu_data = 32'hDEAD_BEEF;
      i_load_valid = 1'b0; i_issue_load_valid = 1'b0;
      #1;
      chk("rst_alu_ready", 64'(o_alu_ready), 64'd0);
      chk("rst_load_ready", 64'(o_load_ready), 64'd0);
      @(posedge clk);
      #1;
      chk("rst_we", 64'(o_rf_write_enable), 64'd0);
      chk("rst_addr", 64'(o_rf_write_address), 64'd0);
      chk("rst_data", 64'(o_rf_write_data), 64'd0);
      chk("rst_busy", 64'(o_rd_busy), 64'd0);
`ifdef WB_RETIRE_COUNT_EN
      chk("rst_retire", o_retire_count, 64'd0);
`endif
      last_addr = 5'd0; last_data = 32'd0; last_known = 1'b1;
      m_busy = 32'd0; m_count = 64'd0;
      q.delete();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      i_alu_valid = 1'b0; i_alu_rd = 5'd0; i_alu_data = 32'd0;
      i_load_valid = 1'b0; i_load_rd = 5'd0; i_load_data = 32'd0;
      i_load_funct3 = 3'b010; i_load_byte_offset = 2'd0;
      i_issue_load_valid = 1'b0; i_issue_load_rd = 5'd0;
      @(posedge clk);
      #1;
      do_reset(1'b0);

      // ALU write lands one cycle later.
      step(1, 5'd5, 32'h0000_1234, 0, 5'd0, 32'd0, 3'b010, 2'd0, 0, 5'd0);
      chk("alu_x5_data", 64'(o_rf_write_data), 64'h0000_1234);

      // Load wins the conflict; ALU goes the following cycle.
      step(1, 5'd7, 32'h7777_0007, 1, 5'd9, 32'hCAFE_F00D, 3'b010, 2'd0, 0, 5'd0);
      chk("conflict_x9", 64'(o_rf_write_data), 64'hCAFE_F00D);
      step(1, 5'd7, 32'h7777_0007, 0, 5'd0, 32'd0, 3'b010, 2'd0, 0, 5'd0);
      chk("conflict_x7", 64'(o_rf_write_address), 64'd7);
      step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 3'b010, 2'd0, 0, 5'd0);

      // Load extraction cases.
      step(0, 5'd0, 32'd0, 1, 5'd10, 32'h0080_0000, 3'b000, 2'd2, 0, 5'd0);
      chk("lb_off2", 64'(o_rf_write_data), 64'hFFFF_FF80);
      step(0, 5'd0, 32'd0, 1, 5'd11, 32'h0080_0000, 3'b100, 2'd2, 0, 5'd0);
      chk("lbu_off2", 64'(o_rf_write_data), 64'h0000_0080);
      step(0, 5'd0, 32'd0, 1, 5'd12, 32'h8000_0000, 3'b001, 2'd2, 0, 5'd0);
      chk("lh_off2", 64'(o_rf_write_data), 64'hFFFF_8000);
      step(0, 5'd0, 32'd0, 1, 5'd13, 32'h8000_0000, 3'b101, 2'd3, 0, 5'd0);
      step(0, 5'd0, 32'd0, 1, 5'd14, 32'h1234_567F, 3'b000, 2'd0, 0, 5'd0);
      step(0, 5'd0, 32'd0, 1, 5'd15, 32'h89AB_CDEF, 3'b011, 2'd1, 0, 5'd0);
      step(0, 5'd0, 32'd0, 1, 5'd16, 32'hF00D_8001, 3'b001, 2'd1, 0, 5'd0);

      // Scoreboard set / same-cycle set-wins / clear / x0.
      step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 3'b010, 2'd0, 1, 5'd3);
      chk("busy3_set", 64'(o_rd_busy[3]), 64'd1);
      step(0, 5'd0, 32'd0, 1, 5'd3, 32'h3333_3333, 3'b010, 2'd0, 1, 5'd3);
      chk("busy3_setwins", 64'(o_rd_busy[3]), 64'd1);
      step(1, 5'd3, 32'h0000_00A3, 0, 5'd0, 32'd0, 3'b010, 2'd0, 1, 5'd8);
      step(0, 5'd0, 32'd0, 1, 5'd3, 32'h0000_0003, 3'b010, 2'd0, 0, 5'd0);
      step(0, 5'd0, 32'd0, 1, 5'd8, 32'h0000_0008, 3'b010, 2'd0, 1, 5'd0);
      chk("busy_x0_none", 64'(o_rd_busy), 64'd0);

      // rd==0 results complete without writing.
      step(1, 5'd0, 32'hFFFF_FFFF, 0, 5'd0, 32'd0, 3'b010, 2'd0, 0, 5'd0);
      step(0, 5'd0, 32'd0, 1, 5'd0, 32'h5555_5555, 3'b010, 2'd0, 0, 5'd0);
      step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 3'b010, 2'd0, 0, 5'd0);

      // Back-to-back ALU, then a load stream starving a waiting ALU result.
      for (int i = 1; i <= 4; i++)
         step(1, 5'(i + 16), 32'h1000_0000 + 32'(i), 0, 5'd0, 32'd0, 3'b010, 2'd0, 0, 5'd0);
      for (int i = 0; i < 3; i++)
         step(1, 5'd21, 32'h2121_2121, 1, 5'(i + 24), 32'hA000_0000 + 32'(i), 3'b010, 2'd0, 0, 5'd0);
      step(1, 5'd21, 32'h2121_2121, 0, 5'd0, 32'd0, 3'b010, 2'd0, 0, 5'd0);

      // Reset mid-activity drops everything.
      step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 3'b010, 2'd0, 1, 5'd6);
      step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 3'b010, 2'd0, 1, 5'd30);
      do_reset(1'b1);
      step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 3'b010, 2'd0, 0, 5'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
